viterbi_chan_ber_mon: RTL and testbench
=======================================

Name: viterbi_chan_ber_mon

Overview:
Parametrised channel-impairment and BER-monitor block placed between the convolutional encoder output and the Viterbi decoder input. It passes code symbols through with one cycle of latency and XORs configurable error masks into them under a run-time mode: clean, periodic, burst or LFSR-random. It also queues the original information bits and compares them against decoder output to count injected channel bits and post-decoder bit errors.

Parameters:
SYM_W, 2, code symbol width (bits per encoder output)
PERIOD_W, 4, periodic/burst injection period = 2**PERIOD_W symbols
LFSR_POLY, 16'hB400, Galois LFSR feedback mask (16-bit LFSR)
LFSR_SEED, 16'hACE1, LFSR value after reset/clear; must be nonzero
REF_DEPTH, 64, reference-bit FIFO depth (power of 2, >= decoder latency + margin)
DEC_SKIP, 0, number of initial decoder outputs discarded before comparison
CNT_W, 32, width of all statistics counters

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-low reset
mode_i  input  2  0=clean, 1=periodic, 2=burst, 3=random
err_mask_i  input  SYM_W  bits flipped in an injected symbol
burst_len_i  input  PERIOD_W  burst length in symbols (mode 2)
thresh_i  input  16  random-mode threshold; inject when lfsr < thresh_i
win_len_i  input  CNT_W  injection window in symbols; 0 = unlimited
clear_i  input  1  synchronous clear of counters, LFSR and FIFO
sym_valid_i  input  1  encoder symbol valid
sym_i  input  SYM_W  encoder symbol
sym_valid_o  output  1  channel symbol valid (to decoder enable)
sym_o  output  SYM_W  possibly corrupted symbol
ref_valid_i  input  1  information bit entering encoder
ref_bit_i  input  1  information bit value
dec_valid_i  input  1  decoder output valid
dec_bit_i  input  1  decoded bit
sym_ct_o  output  CNT_W  symbols passed
inj_bit_ct_o  output  CNT_W  total flipped bits
dec_ct_o  output  CNT_W  decoded bits compared
dec_err_ct_o  output  CNT_W  decoded bit mismatches
window_done_o  output  1  high when win_len_i != 0 and sym_ct_o >= win_len_i
ovf_o  output  1  sticky: reference push while FIFO full
udf_o  output  1  sticky: decoder valid while FIFO empty

Behaviour:
- Reset (rst low, async): all outputs 0; LFSR = LFSR_SEED; FIFO empty; skip counter = 0.
- Channel: registered, latency 1. sym_valid_o <= sym_valid_i; sym_o <= sym_i ^ (inj ? err_mask_i : 0). When sym_valid_i = 0, sym_o holds its previous value.
- inj is evaluated only when sym_valid_i = 1, using sym_ct before the increment. It also requires the window to be open (win_len_i == 0 or sym_ct < win_len_i).
  - mode 0: never inject.
  - mode 1: inject when sym_ct[PERIOD_W-1:0] == all-ones.
  - mode 2: inject when sym_ct[PERIOD_W-1:0] < burst_len_i. burst_len_i = 0 means no injection.
  - mode 3: inject when lfsr < thresh_i. thresh_i = 0 means never inject.
- LFSR steps once per accepted symbol in every mode: lfsr <= lfsr[0] ? (lfsr>>1)^LFSR_POLY : lfsr>>1.
- Mode, mask and threshold inputs are sampled per symbol. A change takes effect on the next accepted symbol.
- Counters:
  - sym_ct +1 per accepted symbol.
  - inj_bit_ct += popcount(err_mask_i) per injected symbol.
  - All counters saturate at all-ones and never wrap.
- Reference FIFO:
  - Push ref_bit_i on ref_valid_i.
  - Pop on dec_valid_i.
  - Simultaneous push and pop on a full FIFO is legal, and neither flag is set.
  - Push when full (no pop): bit dropped, ovf_o set.
  - Pop when empty: no compare, udf_o set. A simultaneous push into an empty FIFO does not bypass.
- Compare: the first DEC_SKIP successful pops are discarded (skip counter). Every later pop increments dec_ct, and dec_err_ct increments when dec_bit_i != popped bit. Compare and count take effect the cycle after dec_valid_i.
- clear_i (synchronous, highest priority):
  - Zeroes counters and flags, reloads LFSR_SEED, empties the FIFO and resets the skip counter.
  - A symbol arriving in the same cycle passes through un-injected and uncounted, and sym_valid_o still follows.
  - ref/dec events in the clear cycle are ignored.
- Reset asserted mid-stream: immediate return to reset values; no partial state is retained.

Test Plan:
- mode 0, 300 symbols of 2'b10, ref bits looped to dec after 20 cycles: sym_o == sym_i delayed 1 cycle, inj_bit_ct=0, dec_ct=300, dec_err_ct=0.
- mode 1, PERIOD_W=4, mask 2'b01, win_len 256, 400 symbols: symbols 15,31,…,255 flipped in bit0, inj_bit_ct=16, window_done_o high after symbol 256.
- mode 2, burst_len 3, mask 2'b11, 64 symbols: symbols 0-2, 16-18, 32-34, 48-50 inverted, inj_bit_ct=24.
- mode 3, thresh 16'h0000 then 16'hFFFF, 100 symbols each: first pass 0 injections; second pass every symbol with lfsr != 16'hFFFF injected; LFSR sequence matches the golden model from LFSR_SEED.
- DEC_SKIP=4, 10 ref bits, decoder returns bits with 2 flipped among bits 5-10: dec_ct=6, dec_err_ct=2. Pushing REF_DEPTH+1 bits without pops sets ovf_o; dec_valid_i on empty sets udf_o.
- clear_i asserted concurrent with a valid symbol mid-burst: that symbol is un-corrupted, all counters read 0 next cycle, LFSR restarts at LFSR_SEED. A rst pulse mid-run produces all-zero outputs asynchronously.

Source files
------------

// File: rtl/viterbi_chan_ber_mon.sv
// Channel-impairment and BER monitor between a convolutional encoder and a Viterbi decoder.
// Symbols pass through one register stage and may have an error mask XORed in. The mode
// selects clean, periodic, burst or LFSR-random injection. Information bits are queued and
// later compared against decoder output.
// Ports:
//   clk, rst (async, active-low)
//   mode_i / err_mask_i / burst_len_i / thresh_i / win_len_i : injection controls, sampled per symbol
//   clear_i : synchronous clear of statistics, LFSR, skip counter and reference FIFO
//   sym_valid_i / sym_i -> sym_valid_o / sym_o : symbol path, latency 1
//   ref_valid_i / ref_bit_i : information bits entering the encoder (FIFO push)
//   dec_valid_i / dec_bit_i : decoder output (FIFO pop + compare)
//   sym_ct_o, inj_bit_ct_o, dec_ct_o, dec_err_ct_o : saturating statistics
//   window_done_o, ovf_o, udf_o : status (ovf/udf are sticky)

// Generic FIFO: registered pointers, read data presented combinationally from the head slot.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: no stall; push is refused when full unless a pop frees a slot in the same cycle.
module vcbm_fifo #(
    parameter int W     = 1,
    parameter int DEPTH = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_vld,
    output logic [W-1:0] pop_dat,
    output logic         push_acc,
    output logic         pop_acc
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_CT  = (AW + 1)'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CT);
    assign pop_acc  = pop_vld & ~empty;
    // A pop in the same cycle frees the slot, so a push on a full FIFO is still accepted.
    assign push_acc = push_vld & (~full | pop_acc);
    assign pop_dat  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + AW'(1);
            if (pop_acc)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_acc, pop_acc})
                2'b10:   count <= count + ONE_CT;
                2'b01:   count <= count - ONE_CT;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_acc && !clr) mem[wr_ptr] <= push_dat;
    end
endmodule

// Channel impairment + BER monitor top level.
// Latency: symbol path 1 cycle; statistics update the cycle after the triggering event.
// Backpressure: none; every symbol, reference bit and decoder bit is consumed when offered.
module viterbi_chan_ber_mon #(
    parameter int          SYM_W     = 2,
    parameter int          PERIOD_W  = 4,
    parameter logic [15:0] LFSR_POLY = 16'hB400,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          REF_DEPTH = 64,
    parameter int          DEC_SKIP  = 0,
    parameter int          CNT_W     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          mode_i,
    input  logic [SYM_W-1:0]    err_mask_i,
    input  logic [PERIOD_W-1:0] burst_len_i,
    input  logic [15:0]         thresh_i,
    input  logic [CNT_W-1:0]    win_len_i,
    input  logic                clear_i,
    input  logic                sym_valid_i,
    input  logic [SYM_W-1:0]    sym_i,
    output logic                sym_valid_o,
    output logic [SYM_W-1:0]    sym_o,
    input  logic                ref_valid_i,
    input  logic                ref_bit_i,
    input  logic                dec_valid_i,
    input  logic                dec_bit_i,
    output logic [CNT_W-1:0]    sym_ct_o,
    output logic [CNT_W-1:0]    inj_bit_ct_o,
    output logic [CNT_W-1:0]    dec_ct_o,
    output logic [CNT_W-1:0]    dec_err_ct_o,
    output logic                window_done_o,
    output logic                ovf_o,
    output logic                udf_o
);
    localparam logic [1:0]          MODE_CLEAN    = 2'd0;
    localparam logic [1:0]          MODE_PERIODIC = 2'd1;
    localparam logic [1:0]          MODE_BURST    = 2'd2;
    localparam logic [1:0]          MODE_RANDOM   = 2'd3;
    localparam logic [CNT_W-1:0]    CNT_MAX       = '1;
    localparam logic [PERIOD_W-1:0] PHASE_LAST    = '1;
    localparam int                  SKIP_W        = $clog2(DEC_SKIP + 1) + 1;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [SYM_W-1:0] v);
        logic [CNT_W-1:0] pc;
        pc = '0;
        for (int i = 0; i < SYM_W; i++) pc = pc + CNT_W'(v[i]);
        return pc;
    endfunction

    // ------------------------------------------------------------------
    // Injection decision (uses sym_ct before this symbol's increment)
    // ------------------------------------------------------------------
    logic [15:0]         lfsr;
    logic [15:0]         lfsr_next;
    logic [PERIOD_W-1:0] phase;
    logic                win_open;
    logic                mode_hit;
    logic                inj;
    logic [CNT_W-1:0]    mask_pop;

    assign phase     = sym_ct_o[PERIOD_W-1:0];
    assign win_open  = (win_len_i == '0) || (sym_ct_o < win_len_i);
    assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ LFSR_POLY) : (lfsr >> 1);
    assign mask_pop  = popcount(err_mask_i);

    always_comb begin
        mode_hit = 1'b0;
        case (mode_i)
            MODE_CLEAN:    mode_hit = 1'b0;
            MODE_PERIODIC: mode_hit = (phase == PHASE_LAST);
            // burst_len_i == 0 makes the compare false for every phase.
            MODE_BURST:    mode_hit = (phase < burst_len_i);
            // thresh_i == 0 can never exceed an unsigned LFSR value.
            MODE_RANDOM:   mode_hit = (lfsr < thresh_i);
            default:       mode_hit = 1'b0;
        endcase
    end

    assign inj = sym_valid_i & win_open & mode_hit;

    assign window_done_o = (win_len_i != '0) && (sym_ct_o >= win_len_i);

    // ------------------------------------------------------------------
    // Symbol path, LFSR and injection statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sym_valid_o  <= 1'b0;
            sym_o        <= '0;
            sym_ct_o     <= '0;
            inj_bit_ct_o <= '0;
            lfsr         <= LFSR_SEED;
        end else begin
            sym_valid_o <= sym_valid_i;
            if (clear_i) begin
                // A symbol coinciding with clear passes clean and is not counted.
                if (sym_valid_i) sym_o <= sym_i;
                sym_ct_o     <= '0;
                inj_bit_ct_o <= '0;
                lfsr         <= LFSR_SEED;
            end else if (sym_valid_i) begin
                sym_o    <= sym_i ^ (inj ? err_mask_i : '0);
                sym_ct_o <= sat_add(sym_ct_o, CNT_W'(1));
                if (inj) inj_bit_ct_o <= sat_add(inj_bit_ct_o, mask_pop);
                lfsr <= lfsr_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference FIFO and decoder comparison
    // ------------------------------------------------------------------
    logic        ref_push;
    logic        dec_pop;
    logic        push_acc;
    logic        pop_acc;
    logic [0:0]  ref_head;
    logic [SKIP_W-1:0] skip_ct;
    logic        skip_done;

    // Events during a clear cycle are ignored entirely.
    assign ref_push = ref_valid_i & ~clear_i;
    assign dec_pop  = dec_valid_i & ~clear_i;

    vcbm_fifo #(
        .W     (1),
        .DEPTH (REF_DEPTH)
    ) u_ref_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (clear_i),
        .push_vld (ref_push),
        .push_dat (ref_bit_i),
        .pop_vld  (dec_pop),
        .pop_dat  (ref_head),
        .push_acc (push_acc),
        .pop_acc  (pop_acc)
    );

    // skip_ct counts up to DEC_SKIP and then parks there.
    assign skip_done = (skip_ct == SKIP_W'(DEC_SKIP));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dec_ct_o     <= '0;
            dec_err_ct_o <= '0;
            skip_ct      <= '0;
            ovf_o        <= 1'b0;
            udf_o        <= 1'b0;
        end else if (clear_i) begin
            dec_ct_o     <= '0;
            dec_err_ct_o <= '0;
            skip_ct      <= '0;
            ovf_o        <= 1'b0;
            udf_o        <= 1'b0;
        end else begin
            if (ref_push && !push_acc) ovf_o <= 1'b1;
            if (dec_pop && !pop_acc)   udf_o <= 1'b1;
            if (pop_acc) begin
                if (!skip_done) begin
                    skip_ct <= skip_ct + SKIP_W'(1);
                end else begin
                    dec_ct_o <= sat_add(dec_ct_o, CNT_W'(1));
                    if (dec_bit_i != ref_head[0])
                        dec_err_ct_o <= sat_add(dec_err_ct_o, CNT_W'(1));
                end
            end
        end
    end
endmodule

// File: tb/tb_viterbi_chan_ber_mon.sv
// Scoreboard bench for viterbi_chan_ber_mon: directed scenarios plus randomized traffic.
// Expected symbols are queued at stimulus time and popped by a negedge monitor.
// Statistics are compared against a queue-based reference model.
module tb_viterbi_chan_ber_mon;
    localparam int          SYM_W = 2;
    localparam int          PW    = 4;
    localparam int          PER   = 1 << PW;
    localparam logic [15:0] POLY  = 16'hB400;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam int          DEPTH = 64;
    localparam int          SKIP  = 4;
    localparam int          CW    = 10;
    localparam int          CMAX  = (1 << CW) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       mode_i;
    logic [SYM_W-1:0] err_mask_i;
    logic [PW-1:0]    burst_len_i;
    logic [15:0]      thresh_i;
    logic [CW-1:0]    win_len_i;
    logic             clear_i;
    logic             sym_valid_i;
    logic [SYM_W-1:0] sym_i;
    logic             sym_valid_o;
    logic [SYM_W-1:0] sym_o;
    logic             ref_valid_i;
    logic             ref_bit_i;
    logic             dec_valid_i;
    logic             dec_bit_i;
    logic [CW-1:0]    sym_ct_o;
    logic [CW-1:0]    inj_bit_ct_o;
    logic [CW-1:0]    dec_ct_o;
    logic [CW-1:0]    dec_err_ct_o;
    logic             window_done_o;
    logic             ovf_o;
    logic             udf_o;

    always #5 clk = ~clk;

    viterbi_chan_ber_mon #(
        .SYM_W(SYM_W), .PERIOD_W(PW), .LFSR_POLY(POLY), .LFSR_SEED(SEED),
        .REF_DEPTH(DEPTH), .DEC_SKIP(SKIP), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .mode_i(mode_i), .err_mask_i(err_mask_i),
        .burst_len_i(burst_len_i), .thresh_i(thresh_i), .win_len_i(win_len_i),
        .clear_i(clear_i), .sym_valid_i(sym_valid_i), .sym_i(sym_i),
        .sym_valid_o(sym_valid_o), .sym_o(sym_o), .ref_valid_i(ref_valid_i),
        .ref_bit_i(ref_bit_i), .dec_valid_i(dec_valid_i), .dec_bit_i(dec_bit_i),
        .sym_ct_o(sym_ct_o), .inj_bit_ct_o(inj_bit_ct_o), .dec_ct_o(dec_ct_o),
        .dec_err_ct_o(dec_err_ct_o), .window_done_o(window_done_o),
        .ovf_o(ovf_o), .udf_o(udf_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [SYM_W-1:0] exp_q[$];
    bit               ref_q[$];
    int               m_sym, m_inj, m_dec, m_err, m_skip;
    bit               m_ovf, m_udf;
    logic [15:0]      m_lfsr;

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic model_reset();
        m_sym = 0; m_inj = 0; m_dec = 0; m_err = 0; m_skip = 0;
        m_ovf = 0; m_udf = 0; m_lfsr = SEED;
        ref_q.delete();
    endtask

    // Drives one cycle of stimulus and advances the model by the matching clock edge.
    task automatic step(input bit sv, input logic [SYM_W-1:0] s, input bit rv, input bit rb,
                        input bit dv, input bit db, input bit clr);
        bit hit, open, b;
        sym_valid_i = sv; sym_i = s; ref_valid_i = rv; ref_bit_i = rb;
        dec_valid_i = dv; dec_bit_i = db; clear_i = clr;
        if (clr) begin
            if (sv) exp_q.push_back(s);
            model_reset();
        end else begin
            if (sv) begin
                open = (win_len_i == 0) || (m_sym < int'(win_len_i));
                case (mode_i)
                    2'd1:    hit = (m_sym % PER) == PER - 1;
                    2'd2:    hit = (m_sym % PER) < int'(burst_len_i);
                    2'd3:    hit = m_lfsr < thresh_i;
                    default: hit = 0;
                endcase
                if (open && hit) begin
                    exp_q.push_back(s ^ err_mask_i);
                    m_inj = sat(m_inj + $countones(err_mask_i));
                end else begin
                    exp_q.push_back(s);
                end
                m_sym  = sat(m_sym + 1);
                m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ POLY) : (m_lfsr >> 1);
            end
            // Pop is judged on occupancy before this cycle's push.
            if (dv) begin
                if (ref_q.size() == 0) m_udf = 1;
                else begin
                    b = ref_q.pop_front();
                    if (m_skip < SKIP) m_skip++;
                    else begin
                        m_dec = sat(m_dec + 1);
                        if (b != db) m_err = sat(m_err + 1);
                    end
                end
            end
            if (rv) begin
                if (ref_q.size() < DEPTH) ref_q.push_back(rb);
                else m_ovf = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_stats(input string tag);
        chk({tag, "_sym_ct"}, sym_ct_o, m_sym);
        chk({tag, "_inj_ct"}, inj_bit_ct_o, m_inj);
        chk({tag, "_dec_ct"}, dec_ct_o, m_dec);
        chk({tag, "_err_ct"}, dec_err_ct_o, m_err);
        chk({tag, "_ovf"}, ovf_o, m_ovf);
        chk({tag, "_udf"}, udf_o, m_udf);
        chk({tag, "_win_done"}, window_done_o, (win_len_i != 0) && (m_sym >= int'(win_len_i)));
    endtask

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        if (rst === 1'b1 && sym_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sym_unexpected: got symbol %0d expected none", sym_o);
            end else begin
                chk("sym_o", sym_o, exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    bit ref_bits[300];
    bit dec_bits[10];

    initial begin
        rst = 1'b0;
        mode_i = 0; err_mask_i = 0; burst_len_i = 0; thresh_i = 0; win_len_i = 0;
        clear_i = 0; sym_valid_i = 0; sym_i = 0; ref_valid_i = 0; ref_bit_i = 0;
        dec_valid_i = 0; dec_bit_i = 0;
        model_reset();
        #12;
        chk("rst_sym_valid", sym_valid_o, 0);
        chk("rst_sym", sym_o, 0);
        check_stats("rst");
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // A: clean channel, reference looped back 20 cycles later
        mode_i = 0; err_mask_i = 2'b11;
        for (int i = 0; i < 300; i++) ref_bits[i] = 1'($urandom);
        for (int i = 0; i < 320; i++)
            step(i < 300, 2'b10, i < 300, (i < 300) ? ref_bits[i] : 1'b0,
                 i >= 20, (i >= 20) ? ref_bits[i - 20] : 1'b0, 0);
        idle(2);
        check_stats("A");
        chk("A_dec_ct_const", dec_ct_o, 300 - SKIP);

        // B: periodic injection inside a 256-symbol window
        step(0, '0, 0, 0, 0, 0, 1);
        mode_i = 1; err_mask_i = 2'b01; win_len_i = 256;
        for (int i = 0; i < 400; i++) step(1, 2'($urandom), 0, 0, 0, 0, 0);
        idle(1);
        check_stats("B");
        chk("B_inj_const", inj_bit_ct_o, 16);
        chk("B_win_done_const", window_done_o, 1);

        // C: burst of 3 per 16 symbols, both bits inverted
        step(0, '0, 0, 0, 0, 0, 1);
        mode_i = 2; err_mask_i = 2'b11; burst_len_i = 3; win_len_i = 0;
        for (int i = 0; i < 64; i++) step(1, 2'($urandom), 0, 0, 0, 0, 0);
        idle(1);
        check_stats("C");
        chk("C_inj_const", inj_bit_ct_o, 24);

        // D: random mode, never then (almost) always
        step(0, '0, 0, 0, 0, 0, 1);
        mode_i = 3; err_mask_i = 2'b10; thresh_i = 16'h0000;
        for (int i = 0; i < 100; i++) step(1, 2'($urandom), 0, 0, 0, 0, 0);
        idle(1);
        check_stats("D0");
        chk("D0_inj_const", inj_bit_ct_o, 0);
        thresh_i = 16'hFFFF;
        for (int i = 0; i < 100; i++) step(1, 2'($urandom), 0, 0, 0, 0, 0);
        idle(1);
        check_stats("D1");

        // E: decoder skip and compare, then FIFO boundaries
        step(0, '0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            dec_bits[i] = 1'($urandom);
            step(0, '0, 1, dec_bits[i], 0, 0, 0);
        end
        for (int i = 0; i < 10; i++) begin
            step(0, '0, 0, 0, 1, dec_bits[i] ^ ((i == 6) || (i == 8)), 0);
            check_stats("E_pop");
        end
        chk("E_dec_const", dec_ct_o, 6);
        chk("E_err_const", dec_err_ct_o, 2);
        for (int i = 0; i < DEPTH + 1; i++) step(0, '0, 1, 1'($urandom), 0, 0, 0);
        idle(1);
        check_stats("E_ovf");
        chk("E_ovf_const", ovf_o, 1);
        step(0, '0, 0, 0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) step(0, '0, 1, 1'($urandom), 0, 0, 0);
        step(0, '0, 1, 1, 1, 1, 0);
        idle(1);
        check_stats("E_full_pp");
        step(0, '0, 0, 0, 0, 0, 1);
        step(0, '0, 1, 1, 1, 0, 0);
        idle(1);
        check_stats("E_udf");
        for (int i = 0; i < 6; i++) step(0, '0, 0, 0, 1, 1, 0);
        idle(1);
        check_stats("E_nobypass");

        // F: clear during a burst, then LFSR restart check in random mode
        step(0, '0, 0, 0, 0, 0, 1);
        mode_i = 2; err_mask_i = 2'b11; burst_len_i = 8;
        step(1, 2'b01, 1, 1, 0, 0, 0);
        step(1, 2'b10, 0, 0, 0, 0, 0);
        step(1, 2'b01, 1, 0, 1, 0, 1);
        check_stats("F_clr");
        chk("F_sym_ct_const", sym_ct_o, 0);
        mode_i = 3; thresh_i = 16'h8000;
        for (int i = 0; i < 50; i++) step(1, 2'($urandom), 0, 0, 0, 0, 0);
        idle(1);
        check_stats("F_lfsr");

        // G: counter saturation
        step(0, '0, 0, 0, 0, 0, 1);
        mode_i = 3; thresh_i = 16'hFFFF; err_mask_i = 2'b11; win_len_i = 0;
        for (int i = 0; i < 1100; i++) step(1, 2'($urandom), 0, 0, 0, 0, 0);
        idle(1);
        check_stats("G");
        chk("G_sym_sat", sym_ct_o, CMAX);

        // H: randomized traffic with occasional clears
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) begin
                mode_i = 2'($urandom);
                err_mask_i = 2'($urandom);
                burst_len_i = 4'($urandom);
                case ($urandom_range(0, 2))
                    0:       thresh_i = 16'h0000;
                    1:       thresh_i = 16'hFFFF;
                    default: thresh_i = 16'($urandom);
                endcase
                win_len_i = ($urandom_range(0, 1) == 0) ? '0 : CW'($urandom_range(1, 900));
            end
            step($urandom_range(0, 3) != 0, 2'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), $urandom_range(0, 399) == 0);
            if (i % 100 == 99) check_stats("H");
        end
        idle(1);
        check_stats("H_end");

        // I: asynchronous reset mid-stream
        idle(1);
        chk("I_drain", exp_q.size(), 0);
        step(1, 2'b11, 1, 1, 0, 0, 0);
        #2 rst = 1'b0;
        #1;
        chk("I_sym_valid", sym_valid_o, 0);
        chk("I_sym", sym_o, 0);
        sym_valid_i = 0; ref_valid_i = 0; dec_valid_i = 0; clear_i = 0;
        model_reset();
        exp_q.delete();
        check_stats("I_rst");
        #10 rst = 1'b1;
        @(posedge clk); #1;
        mode_i = 3; thresh_i = 16'h6000; err_mask_i = 2'b01; win_len_i = 0;
        for (int i = 0; i < 40; i++) step(1, 2'($urandom), 0, 0, 0, 0, 0);
        idle(2);
        check_stats("I_after");
        chk("I_final_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
